alu: RTL and testbench

- 64-bit integer ALU for the Y86 execute stage.
- Performs add, subtract, bitwise AND or bitwise XOR on two signed 64-bit operands.
- Produces a registered 64-bit result and a registered signed-overflow flag.
- The execute stage feeds operands and function select; downstream condition-code logic consumes result/overflow one cycle later.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_if.sv | 23 ++
 rtl/alu_adder.sv | 28 ++
 rtl/alu.sv | 63 ++++++
 tb/tb_alu.sv | 138 +++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the Y86 execute-stage ALU: operation encodings and default width.
package alu_pkg;

    localparam int ALU_WIDTH = 64;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/function-select bus into the ALU and registered result/overflow back out.
interface alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    alu_op_e            sel;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               cin;
    logic [WIDTH-1:0]   result;
    logic               overflow;

    modport master (
        output sel, a, b, cin,
        input  result, overflow
    );

    modport slave (
        input  sel, a, b, cin,
        output result, overflow
    );
endinterface

// File: rtl/alu_adder.sv
// Combinational ripple-carry adder from per-bit full adders, with two's-complement overflow.
module alu_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c0,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);
    // carry[gi] is the carry into bit gi; the carry out of the MSB is never needed.
    logic [WIDTH-1:0] carry;

    assign carry[0] = c0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum[gi] = x[gi] ^ y[gi] ^ carry[gi];
            if (gi < WIDTH - 1) begin : g_carry
                assign carry[gi+1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
            end
        end
    endgenerate

    assign overflow = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
endmodule

// File: rtl/alu.sv
// Y86 execute-stage ALU: add/sub/and/xor with a one-cycle registered result and overflow flag.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);
    logic             is_sub;
    logic [WIDTH-1:0] add_y;
    logic             add_c0;
    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;
    logic [WIDTH-1:0] result_d, result_q;
    logic             overflow_d, overflow_q;

    // SUB reuses the adder as a + ~b + 1, so cin only matters for ADD.
    assign is_sub = (bus.sel == ALU_SUB);
    assign add_y  = is_sub ? ~bus.b : bus.b;
    assign add_c0 = is_sub ? 1'b1 : bus.cin;

    alu_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .x        (bus.a),
        .y        (add_y),
        .c0       (add_c0),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    always_comb begin
        result_d   = '0;
        overflow_d = 1'b0;
        case (bus.sel)
            ALU_ADD, ALU_SUB: begin
                result_d   = add_sum;
                overflow_d = add_ovf;
            end
            ALU_AND: result_d = bus.a & bus.b;
            ALU_XOR: result_d = bus.a ^ bus.b;
            default: begin
                result_d   = '0;
                overflow_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the alu: reset, each operation, boundaries and back-to-back issue.
module tb_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_if #(.WIDTH(ALU_WIDTH)) bus ();

    alu #(.WIDTH(ALU_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        alu_op_e     sel;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] r;
        logic        o;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic drive(input alu_op_e sel, input logic [63:0] a, input logic [63:0] b,
                         input logic cin);
        bus.sel = sel;
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input alu_op_e sel, input logic [63:0] a,
                          input logic [63:0] b, input logic cin,
                          input logic [63:0] er, input logic eo);
        drive(sel, a, b, cin);
        step();
        check({tag, "_res"}, bus.result, er);
        check({tag, "_ovf"}, {63'd0, bus.overflow}, {63'd0, eo});
    endtask

    initial begin
        vecs[0] = '{ALU_ADD, 64'h71ED6D, 64'h7A4886, 1'b0, 64'h0000000000EC35F3, 1'b0};
        vecs[1] = '{ALU_SUB, 64'h9111111111111111, 64'hEEEEEEEEEEEEEEEE, 1'b0,
                    64'hA222222222222223, 1'b0};
        vecs[2] = '{ALU_AND, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0,
                    64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[3] = '{ALU_XOR, 64'h03FA402BFF14FC06, 64'hFFFFF9025F901AF1, 1'b0,
                    64'hFC05B929A084E6F7, 1'b0};
        vecs[4] = '{ALU_ADD, 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h8000000000000000, 1'b1};
        vecs[5] = '{ALU_SUB, 64'h8000000000000000, 64'h1, 1'b0, 64'h7FFFFFFFFFFFFFFF, 1'b1};
        vecs[6] = '{ALU_AND, 64'hF0F0F0F0F0F0F0F0, 64'h00FF00FF00FF00FF, 1'b1,
                    64'h00F000F000F000F0, 1'b0};
        vecs[7] = '{ALU_XOR, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 1'b1,
                    64'hFFFFFFFFFFFFFFFF, 1'b0};

        // Reset held for two edges with an ADD pending, then released.
        rst_n = 1'b0;
        drive(ALU_ADD, 64'd5, 64'd7, 1'b0);
        step();
        check("rst0_res", bus.result, 64'd0);
        check("rst0_ovf", {63'd0, bus.overflow}, 64'd0);
        step();
        check("rst1_res", bus.result, 64'd0);
        check("rst1_ovf", {63'd0, bus.overflow}, 64'd0);
        rst_n = 1'b1;
        run_op("rel", ALU_ADD, 64'd5, 64'd7, 1'b0, 64'd12, 1'b0);

        run_op("add", ALU_ADD, 64'h71ED6D, 64'h7A4886, 1'b0, 64'h0000000000EC35F3, 1'b0);
        run_op("add_ovf", ALU_ADD, 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0,
               64'h8000000000000000, 1'b1);
        run_op("add_cin", ALU_ADD, 64'd0, 64'd0, 1'b1, 64'd1, 1'b0);
        run_op("add_wrap", ALU_ADD, 64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'd0, 1'b0);
        run_op("add_novf", ALU_ADD, 64'h8000000000000000, 64'h8000000000000000, 1'b0,
               64'd0, 1'b1);
        run_op("sub", ALU_SUB, 64'h9111111111111111, 64'hEEEEEEEEEEEEEEEE, 1'b0,
               64'hA222222222222223, 1'b0);
        run_op("sub_ovf", ALU_SUB, 64'h8000000000000000, 64'h1, 1'b0,
               64'h7FFFFFFFFFFFFFFF, 1'b1);
        run_op("sub_cin", ALU_SUB, 64'h8000000000000000, 64'h1, 1'b1,
               64'h7FFFFFFFFFFFFFFF, 1'b1);
        run_op("sub_neg", ALU_SUB, 64'd3, 64'd5, 1'b0, 64'hFFFFFFFFFFFFFFFE, 1'b0);
        run_op("and", ALU_AND, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0,
               64'hFFFFFFFFFFFFFFFC, 1'b0);
        run_op("xor", ALU_XOR, 64'h03FA402BFF14FC06, 64'hFFFFF9025F901AF1, 1'b0,
               64'hFC05B929A084E6F7, 1'b0);

        // Back-to-back: before each edge the previous result must still be held.
        begin
            logic [63:0] prev_r;
            logic        prev_o;
            prev_r = 64'hFC05B929A084E6F7;
            prev_o = 1'b0;
            for (int i = 0; i < 8; i++) begin
                drive(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin);
                #1;
                check($sformatf("b2b%0d_hold", i), bus.result, prev_r);
                step();
                check($sformatf("b2b%0d_res", i), bus.result, vecs[i].r);
                check($sformatf("b2b%0d_ovf", i), {63'd0, bus.overflow}, {63'd0, vecs[i].o});
                prev_r = vecs[i].r;
                prev_o = vecs[i].o;
            end
            if (prev_o !== vecs[7].o) $display("note: unexpected table state");
        end

        // Mid-stream reset overrides an overflowing ADD, then issue resumes.
        rst_n = 1'b0;
        run_op("mid_rst", ALU_ADD, 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'd0, 1'b0);
        rst_n = 1'b1;
        run_op("post_rst", ALU_XOR, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 1'b0,
               64'hFFFFFFFFFFFFFFFF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
